wb_ram: RTL
===========

WB_RAM -- requirements
Module: wb_ram

Interface
REQ-001 Parameter DEPTH_WORDS, default 4096, is the number of 32-bit words; it SHALL be a power of two.
REQ-002 Parameter WAIT_CYCLES, default 1, is the wait states between acceptance and ack, range 0..15.
REQ-003 Parameter INIT_FILE, default "", names a hex image loaded at elaboration; empty means no load.
REQ-004 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-005 Port clk, input, 1: the clock.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port mem_wb, WISHBONE_IF.slave: addr, we, stb, cyc, width, data_write are inputs; data_read and ack are outputs.
REQ-008 Port oFault, output, 1: sticky misalignment flag; cleared only by rst.

Function
REQ-009 The FSM SHALL have states IDLE, WAIT and ACK.
REQ-010 In IDLE, when cyc&stb is sampled high, the block SHALL accept: capture addr, we, width and data_write, then go to WAIT, or to ACK if WAIT_CYCLES=0.
REQ-011 WAIT SHALL count WAIT_CYCLES clocks, then go to ACK.
REQ-012 ack SHALL be high exactly one cycle, in ACK, then the FSM returns to IDLE.
REQ-013 Timing: stb sampled at edge N gives ack high in cycle N+1+WAIT_CYCLES.
REQ-014 Back-to-back: stb held high through ack SHALL be re-accepted at the IDLE edge after ACK. Sustained throughput is one access per 2+WAIT_CYCLES cycles.
REQ-015 If cyc or stb falls while in WAIT or ACK, the FSM SHALL return to IDLE next cycle with ack low and no memory write.
REQ-016 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so out-of-range addresses wrap modulo DEPTH_WORDS.
REQ-017 Writes SHALL commit on the ACK-cycle edge, and only if cyc&stb is still high.
- eDW_W: all 4 lanes.
- eDW_H: lanes selected by addr[1], from data_write[15:0].
- eDW_B: the lane selected by addr[1:0], from data_write[7:0].
REQ-018 Reads SHALL drive data_read while ack is high:
- eDW_W: the full word.
- eDW_H / eDW_B: the selected lanes, right-justified and zero-extended.
REQ-019 data_read SHALL be 0 whenever ack is low.
REQ-020 A read and a write to the same word on consecutive transactions SHALL return the newly written data; there is no read-during-write hazard.

Reset
REQ-021 On rst, the FSM SHALL go to IDLE, the wait counter to 0, ack to 0, data_read to 0 and oFault to 0.
REQ-022 Memory contents SHALL NOT be cleared by rst.
REQ-023 rst asserted mid-transaction SHALL abort it: no ack and no write.

Configuration
REQ-024 With WB_RAM_ALIGN_CHECK_EN defined, a misaligned access (eDW_W with addr[1:0]!=0, or eDW_H with addr[0]!=0) SHALL:
- still ack at normal latency;
- suppress the write;
- return data_read=0;
- set oFault.
REQ-025 Without WB_RAM_ALIGN_CHECK_EN, low address bits SHALL be ignored for lane selection beyond the width, and oFault SHALL be tied 0.

Structure
REQ-026 The width enum (eDW_B, eDW_H, eDW_W) and the FSM state typedef SHALL live in the shared memory package.
REQ-027 Lane-select and extract logic SHALL be a combinational sub-module wb_lane_align.
REQ-028 The storage array SHALL be inferred inside wb_ram.

Verification
REQ-029 With WAIT_CYCLES=1, a word write of 0xDEADBEEF to 0x10 followed by a word read of 0x10 -> ack in cycle N+2 for each, and the read returns 0xDEADBEEF.
REQ-030 Byte write 0xAA to 0x13 over a word holding 0x11223344 -> word read returns 0xAA223344, and a byte read of 0x13 returns 0x000000AA.
REQ-031 stb held high for 3 sequential reads at 0x0, 0x4, 0x8 -> exactly 3 single-cycle acks, spaced 3 cycles apart.
REQ-032 stb dropped in the WAIT cycle of a write of 0x12345678 -> no ack, and a later read returns the old value.
REQ-033 With DEPTH_WORDS=4096, a write to 0x4000 followed by a read of 0x0 -> the written value (wrap).
REQ-034 With WB_RAM_ALIGN_CHECK_EN, a word write to 0x2 -> ack, no write, oFault=1 until rst; rst mid-WAIT -> no ack, and ack, data_read and oFault read 0.

Source files
------------

// File: rtl/wb_ram_pkg.sv
// Shared types for the wishbone RAM: access width and the access FSM states.
package wb_ram_pkg;

    typedef enum logic [1:0] {
        eDW_B = 2'd0,
        eDW_H = 2'd1,
        eDW_W = 2'd2
    } dw_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

    localparam int DATA_W = 32;

endpackage

// File: rtl/wb_ram_if.sv
// Classic wishbone bus bundle used by wb_ram; the slave modport is the RAM side.
interface WISHBONE_IF;
    import wb_ram_pkg::*;

    logic [31:0] addr;
    logic        we;
    logic        stb;
    logic        cyc;
    dw_e         width;
    logic [31:0] data_write;
    logic [31:0] data_read;
    logic        ack;

    modport slave (
        input  addr, we, stb, cyc, width, data_write,
        output data_read, ack
    );

    modport master (
        output addr, we, stb, cyc, width, data_write,
        input  data_read, ack
    );
endinterface

// File: rtl/wb_lane_align.sv
// Byte-lane steering: write enables/replicated write data and right-justified read extract.
module wb_lane_align
    import wb_ram_pkg::*;
#(
    parameter bit ALIGN_CHECK = 1'b0
) (
    input  dw_e         width,
    input  logic [1:0]  lane,
    input  logic [31:0] data_write,
    input  logic [31:0] word,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        misaligned
);

    always_comb begin
        byte_en    = 4'hF;
        wr_data    = data_write;
        rd_data    = word;
        misaligned = 1'b0;
        case (width)
            eDW_B: begin
                byte_en = 4'b0001 << lane;
                wr_data = {4{data_write[7:0]}};
                rd_data = {24'h0, word[{lane, 3'b000} +: 8]};
            end
            eDW_H: begin
                byte_en    = lane[1] ? 4'b1100 : 4'b0011;
                wr_data    = {2{data_write[15:0]}};
                rd_data    = {16'h0, (lane[1] ? word[31:16] : word[15:0])};
                misaligned = ALIGN_CHECK & lane[0];
            end
            default: begin
                misaligned = ALIGN_CHECK & (|lane);
            end
        endcase
    end

endmodule

// File: rtl/wb_ram.sv
// Wishbone slave RAM with configurable wait states and byte/half/word lanes.
// Define WB_RAM_ALIGN_CHECK_EN to fault and suppress misaligned accesses.
module wb_ram
    import wb_ram_pkg::*;
#(
    parameter int    DEPTH_WORDS = 4096,
    parameter int    WAIT_CYCLES = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic      clk,
    input  logic      rst,
    WISHBONE_IF.slave mem_wb,
    output logic      oFault
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [31:0] mem [DEPTH_WORDS];

    state_e      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [AW-1:0] idx_q;
    logic [1:0]  lane_q;
    logic        we_q;
    dw_e         width_q;
    logic [31:0] wdata_q;
    logic [31:0] rword_q;

    logic [3:0]  byte_en;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        misaligned;
    logic        req;
    logic        commit;

    assign req    = mem_wb.cyc & mem_wb.stb;
    // An access completes only if the master still holds the request in ACK.
    assign commit = (state == ACK) & req & ~rst;

`ifdef WB_RAM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;

    always_ff @(posedge clk) begin
        if (rst)
            oFault <= 1'b0;
        else if (commit && misaligned)
            oFault <= 1'b1;
    end
`else
    localparam bit ALIGN_CHECK = 1'b0;

    assign oFault = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    cnt_nx   = 4'd0;
                    state_nx = (WAIT_CYCLES == 0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (!req)
                    state_nx = IDLE;
                else if (cnt == WAIT_LAST)
                    state_nx = ACK;
                else
                    cnt_nx = cnt + 4'd1;
            end
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Read word is fetched at acceptance so it is ready even with zero wait states.
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            idx_q   <= mem_wb.addr[AW+1:2];
            lane_q  <= mem_wb.addr[1:0];
            we_q    <= mem_wb.we;
            width_q <= mem_wb.width;
            wdata_q <= mem_wb.data_write;
            rword_q <= mem[mem_wb.addr[AW+1:2]];
        end
    end

    always_ff @(posedge clk) begin
        if (commit && we_q && !misaligned) begin
            for (int b = 0; b < 4; b++)
                if (byte_en[b])
                    mem[idx_q][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
    end

    wb_lane_align #(.ALIGN_CHECK(ALIGN_CHECK)) u_lane (
        .width      (width_q),
        .lane       (lane_q),
        .data_write (wdata_q),
        .word       (rword_q),
        .byte_en    (byte_en),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .misaligned (misaligned)
    );

    assign mem_wb.ack       = (state == ACK) & req;
    assign mem_wb.data_read = (mem_wb.ack && !misaligned) ? rd_data : 32'h0;

endmodule
